// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a valid/ready handshake.
// Barrel levels are spread over STAGES registers, LSB levels first; a stalled stage back-pressures upstream.
module pipe_shifter #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [$clog2(DATA_W)-1:0] in_shamt,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_err
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int LPS  = (SH_W + STAGES - 1) / STAGES;

    typedef struct packed {
        logic [2:0]        op;
        logic [SH_W-1:0]   shamt;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } stage_t;

    stage_t            st_in;
    stage_t            src  [STAGES];
    stage_t            nxt  [STAGES];
    stage_t            st_q [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES:0]   vld_pipe;

    // vld_pipe[0] is the incoming request, vld_pipe[s+1] is stage s
    assign vld_pipe = {vld_q, in_valid};

    // Illegal ops enter with zero data, so every later level leaves them at zero.
    always_comb begin
        st_in.op    = in_op;
        st_in.shamt = in_shamt;
        st_in.tag   = in_tag;
        st_in.err   = !(in_op inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b110});
        st_in.data  = st_in.err ? '0 : in_data;
    end

    always_comb begin
        src[0] = st_in;
        for (int s = 1; s < STAGES; s++) src[s] = st_q[s-1];
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            nxt[s] = src[s];
            for (int l = 0; l < SH_W; l++) begin
                if ((l / LPS) == s && src[s].shamt[l]) begin
                    case (src[s].op)
                        3'b000:  nxt[s].data = nxt[s].data << (1 << l);
                        3'b010:  nxt[s].data = nxt[s].data >> (1 << l);
                        3'b011:  nxt[s].data = DATA_W'($signed(nxt[s].data) >>> (1 << l));
                        3'b100:  nxt[s].data = (nxt[s].data << (1 << l)) |
                                               (nxt[s].data >> (DATA_W - (1 << l)));
                        3'b110:  nxt[s].data = (nxt[s].data >> (1 << l)) |
                                               (nxt[s].data << (DATA_W - (1 << l)));
                        default: nxt[s].data = nxt[s].data;
                    endcase
                end
            end
        end
    end

    // A stage can load when it is empty or any stage downstream of it can drain.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            r      = !vld_q[s] || r;
            rdy[s] = r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) st_q[s] <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (rdy[s]) begin
                    vld_q[s] <= vld_pipe[s];
                    if (vld_pipe[s]) st_q[s] <= nxt[s];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES];
    assign out_data  = st_q[STAGES-1].data;
    assign out_tag   = st_q[STAGES-1].tag;
    assign out_err   = st_q[STAGES-1].err;
endmodule
